// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : writeback stage of the 5-stage MIPS pipeline.
//
// Consumes the M/W pipeline register, extends load data, selects the
// writeback value, owns the 32x32 general register file (with write-through
// bypass on both D-stage read ports) and counts retired instructions.
//
// Ports
//   clk      in   1         system clock, all state on rising edge
//   reset    in   1         synchronous, active-high reset
//   res_w    in   3         writeback source (0 none,1 ALU,2 DM,3 PC8,4-7 none)
//   a3_w     in   5         destination register number
//   instr_w  in   32        instruction in W, 0 = bubble
//   ao_w     in   32        ALU result / memory address
//   dr_w     in   32        raw data-memory read word
//   pc8_w    in   32        PC+8 for link instructions
//   ra1/ra2  in   5         D-stage read addresses
//   rd1/rd2  out  32        D-stage read data (bypassed)
//   wd_w     out  32        selected writeback value / W forward source
//   we_w     out  1         register-file write performed this cycle
//   retired  out  RETIRE_W  count of non-bubble instructions completed
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          res_w,
  input  logic [4:0]          a3_w,
  input  logic [31:0]         instr_w,
  input  logic [31:0]         ao_w,
  input  logic [31:0]         dr_w,
  input  logic [31:0]         pc8_w,
  input  logic [4:0]          ra1,
  input  logic [4:0]          ra2,
  output logic [31:0]         rd1,
  output logic [31:0]         rd2,
  output logic [31:0]         wd_w,
  output logic                we_w,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  // Extract the addressed byte/halfword and extend it; unknown opcodes
  // (including lw) pass the raw word through.
  function automatic logic [31:0] load_ext(
    input logic [5:0]  op,
    input logic [1:0]  addr,
    input logic [31:0] dr
  );
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    byte_s = 8'h00;
    half_s = 16'h0000;
    res_s  = dr;
    case (addr)
      2'd0:    byte_s = dr[7:0];
      2'd1:    byte_s = dr[15:8];
      2'd2:    byte_s = dr[23:16];
      2'd3:    byte_s = dr[31:24];
      default: byte_s = 8'h00;
    endcase
    // Halfword select ignores addr[0].
    if (addr[1]) begin
      half_s = dr[31:16];
    end else begin
      half_s = dr[15:0];
    end
    case (op)
      OP_LB:   res_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  res_s = {24'h000000, byte_s};
      OP_LH:   res_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  res_s = {16'h0000, half_s};
      default: res_s = dr;
    endcase
    return res_s;
  endfunction

  logic [31:0]         regs_r [32];
  logic [RETIRE_W-1:0] retired_r;

  // Writeback value select; zero whenever no write is selected.
  always_comb begin
    wd_w = 32'h0000_0000;
    case (res_w)
      3'd1:    wd_w = ao_w;
      3'd2:    wd_w = load_ext(instr_w[31:26], ao_w[1:0], dr_w);
      3'd3:    wd_w = pc8_w;
      default: wd_w = 32'h0000_0000;
    endcase
  end

  // Write enable: valid source, non-zero destination, and not in reset.
  always_comb begin
    we_w = 1'b0;
    if (!reset && (res_w != 3'd0) && (res_w <= 3'd3) && (a3_w != 5'd0)) begin
      we_w = 1'b1;
    end else begin
      we_w = 1'b0;
    end
  end

  // Register file; reg[0] is never written because we_w excludes a3_w==0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (we_w) begin
      regs_r[a3_w] <= wd_w;
    end
  end

  // Retired-instruction counter; bubbles do not count, wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= '0;
    end else if (instr_w != 32'h0000_0000) begin
      retired_r <= retired_r + RETIRE_W'(1);
    end
  end

  assign retired = retired_r;

  // Read port 1 with write-through bypass so same-cycle writes are visible.
  always_comb begin
    rd1 = 32'h0000_0000;
    if (ra1 == 5'd0) begin
      rd1 = 32'h0000_0000;
    end else if (we_w && (a3_w == ra1)) begin
      rd1 = wd_w;
    end else begin
      rd1 = regs_r[ra1];
    end
  end

  // Read port 2 with write-through bypass.
  always_comb begin
    rd2 = 32'h0000_0000;
    if (ra2 == 5'd0) begin
      rd2 = 32'h0000_0000;
    end else if (we_w && (a3_w == ra2)) begin
      rd2 = wd_w;
    end else begin
      rd2 = regs_r[ra2];
    end
  end

endmodule
